// File: rtl/norm_shifter_pipe.sv
// Pipelined zero-normaliser: strips trailing zeros (shift right) or leading zeros (shift left),
// one binary shift stage per register, with valid/ready flow control and a tag sideband.
module norm_shifter_pipe #(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 4,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iData,
    input  logic             iMsb,
    input  logic [TAG_W-1:0] iTag,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oData,
    output logic [SW-1:0]    oShift,
    output logic             oZero,
    output logic [TAG_W-1:0] oTag
);

    logic adv;

    assign adv    = ~oValid | iReady;
    assign oReady = adv;

    // Pipeline position s handles shift amount 2**(SW-1-s): widest shift first.
    for (genvar s = 0; s < SW; s++) begin : stg
        localparam int K   = SW - 1 - s;
        localparam int AMT = 2 ** K;

        logic [WIDTH-1:0] d_in, d_n, d_q;
        logic [SW-1:0]    sh_in, sh_n, sh_q;
        logic [TAG_W-1:0] tag_in, tag_q;
        logic             msb_in, z_in, z_q, v_in, v_q;
        logic             hit;

        if (s == 0) begin : src
            assign d_in   = iData;
            assign sh_in  = '0;
            assign msb_in = iMsb;
            assign z_in   = ~|iData;
            assign tag_in = iTag;
            assign v_in   = iValid;
        end else begin : src
            assign d_in   = stg[s-1].d_q;
            assign sh_in  = stg[s-1].sh_q;
            assign msb_in = stg[s-1].keep.msb_q;
            assign z_in   = stg[s-1].z_q;
            assign tag_in = stg[s-1].tag_q;
            assign v_in   = stg[s-1].v_q;
        end

        always_comb begin
            hit  = msb_in ? (d_in[WIDTH-1 -: AMT] == '0) : (d_in[AMT-1:0] == '0);
            d_n  = d_in;
            sh_n = sh_in;
            if (hit) begin
                d_n     = msb_in ? (d_in << AMT) : (d_in >> AMT);
                sh_n[K] = 1'b1;
            end
        end

        always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
                v_q   <= 1'b0;
                d_q   <= '0;
                sh_q  <= '0;
                z_q   <= 1'b0;
                tag_q <= '0;
            end else if (adv) begin
                v_q   <= v_in;
                d_q   <= d_n;
                sh_q  <= sh_n;
                z_q   <= z_in;
                tag_q <= tag_in;
            end
        end

        // The mode bit is only needed by later stages, so the last stage has no register for it.
        if (s < SW - 1) begin : keep
            logic msb_q;
            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst)
                    msb_q <= 1'b0;
                else if (adv)
                    msb_q <= msb_in;
            end
        end
    end

    assign oValid = stg[SW-1].v_q;
    assign oData  = stg[SW-1].d_q;
    assign oShift = stg[SW-1].sh_q;
    assign oZero  = stg[SW-1].z_q;
    assign oTag   = stg[SW-1].tag_q;

endmodule
